// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync and
// blanking outputs that are zero-skew with hpos/vpos, plus line/frame strobes.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] frame_count_q, frame_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       h_last, v_last;

    always_comb begin
        h_last        = (hpos_q == H_LAST);
        v_last        = (vpos_q == V_LAST);
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        frame_count_d = frame_count_q;
        if (ce) begin
            hpos_d = h_last ? 10'd0 : hpos_q + 10'd1;
            if (h_last) begin
                vpos_d = v_last ? 10'd0 : vpos_q + 10'd1;
                if (v_last) frame_count_d = frame_count_q + 10'd1;
            end
        end
        // Decode from the next position so the registered outputs line up with hpos/vpos.
        hsync_d      = ((hpos_d >= HS_START) && (hpos_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d      = ((vpos_d >= VS_START) && (vpos_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        display_on_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            frame_count_q <= 10'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            display_on_q  <= 1'b1;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = frame_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = (hpos_q == 10'd0) && ce;
    assign frame_start = (hpos_q == 10'd0) && (vpos_q == 10'd0) && ce;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_BOTTOM, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_TOP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 clk  input  1  pixel clock; one clock, all logic on rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 ce  input  1  pixel-tick enable; counters advance only when high.
REQ-013 hsync  output  1  horizontal sync, polarity per SYNC_POL.
REQ-014 vsync  output  1  vertical sync, polarity per SYNC_POL.
REQ-015 display_on  output  1  high when the current position is in the visible area.
REQ-016 hpos  output  10  current horizontal position.
REQ-017 vpos  output  10  current vertical position.
REQ-018 line_start  output  1  one-tick strobe at the first pixel of every line.
REQ-019 frame_start  output  1  one-tick strobe at the first pixel of every frame.
REQ-020 frame_count  output  10  frames completed since reset, replaces vsync-clocked animation counters downstream.

Function
REQ-021 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP (525) SHALL define the counter ranges.
REQ-022 hpos SHALL be a register counting 0..H_TOTAL-1, incrementing by 1 on each clk edge where ce=1, and wrapping to 0 after H_TOTAL-1.
REQ-023 vpos SHALL be a register incrementing by 1 only on the ce=1 edge where hpos=H_TOTAL-1, and wrapping to 0 after V_TOTAL-1.
REQ-024 With ce=0, hpos, vpos, frame_count, hsync, vsync and display_on SHALL hold their values.
REQ-025 hsync, vsync and display_on SHALL be registers, updated on the same edge as hpos/vpos from the next position, so they have zero skew relative to hpos/vpos.
REQ-026 hsync SHALL be active iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
REQ-027 vsync SHALL be active iff V_DISPLAY+V_BOTTOM <= vpos <= V_DISPLAY+V_BOTTOM+V_SYNC-1 (490..491).
REQ-028 display_on SHALL be 1 iff hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-029 line_start SHALL equal (hpos==0) AND ce, giving exactly one pulse per line at pixel rate.
REQ-030 frame_start SHALL equal (hpos==0) AND (vpos==0) AND ce.
REQ-031 frame_count SHALL increment by 1 on the ce=1 edge where hpos=H_TOTAL-1 and vpos=V_TOTAL-1, wrapping 1023 -> 0.
REQ-032 All arithmetic SHALL be unsigned; hpos/vpos SHALL never reach H_TOTAL/V_TOTAL.
REQ-033 Inactive sync level SHALL be ~SYNC_POL; active level SHALL be SYNC_POL.

Reset
REQ-034 While reset=1 at a clk edge: hpos=0, vpos=0, frame_count=0, hsync=vsync=~SYNC_POL, display_on=1 (consistent with position 0,0), regardless of ce.
REQ-035 reset SHALL take priority over ce and over any wrap event in the same cycle.
REQ-036 Reset asserted mid-line or mid-frame SHALL restart timing at (0,0) on the next edge; the first ce=1 edge after release moves to hpos=1.
REQ-037 line_start and frame_start are combinational from registered state and ce, so both are high after reset whenever ce=1.

Verification
REQ-038 Reset then ce=1 continuously for 800x525 clocks -> hpos wraps 799->0 each 800 clocks, vpos wraps 524->0, frame_count=1, exactly 525 line_start and 1 additional frame_start pulse observed after the initial one.
REQ-039 Sweep one line with vpos=0 -> hsync low exactly for hpos 656..751 (96 clocks), display_on high exactly for hpos 0..639.
REQ-040 Sweep one frame -> vsync low exactly for vpos 490..491 (1600 clocks), display_on never high when vpos>=480.
REQ-041 ce toggled 1,0,0,1 with hpos=10 -> hpos 11,11,11,12; no strobe while ce=0; sync outputs unchanged.
REQ-042 Reset asserted at hpos=799, vpos=524, ce=1 -> next state hpos=0, vpos=0, frame_count=0 (no increment).
REQ-043 Run 1024 frames with SYNC_POL=1 -> frame_count returns to 0; hsync/vsync active-high with same windows.
